// File: rtl/rv32m_div_unit.sv
// rtl/rv32m_div_unit.sv - iterative RV32M divider (div/divu/rem/remu), restoring radix-2
// Special cases (divide by zero, signed overflow) resolve at accept in one cycle.
module rv32m_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  localparam logic [5:0] CNT_LAST = 6'(XLEN - 1);

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic            op_rem_q, op_rem_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic            in_ready_q, in_ready_d;

  logic            op_signed, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] a_abs, b_abs, spec_result;
  logic [XLEN:0]   shifted, diff;
  logic            ge;
  logic [XLEN-1:0] rem_n, dvd_n, quo_fix, rem_fix;

  always_comb begin
    op_signed   = ~in_op[0];
    a_neg       = op_signed & in_a[XLEN-1];
    b_neg       = op_signed & in_b[XLEN-1];
    a_abs       = a_neg ? (~in_a + 1'b1) : in_a;
    b_abs       = b_neg ? (~in_b + 1'b1) : in_b;
    div_zero    = (in_b == '0);
    ovf         = op_signed & (in_a == {1'b1, {(XLEN-1){1'b0}}}) & (in_b == '1);
    // Overflow quotient equals the dividend itself; the remainder is zero.
    spec_result = div_zero ? (in_op[1] ? in_a : '1) : (in_op[1] ? '0 : in_a);

    // The dividend register doubles as the quotient: bits enter at the bottom.
    shifted = {rem_q, dvd_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = ~diff[XLEN];
    rem_n   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    dvd_n   = {dvd_q[XLEN-2:0], ge};
    quo_fix = neg_quo_q ? (~dvd_n + 1'b1) : dvd_n;
    rem_fix = neg_rem_q ? (~rem_n + 1'b1) : rem_n;

    state_d      = state_q;
    cnt_d        = cnt_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    rem_d        = rem_q;
    op_rem_d     = op_rem_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;

    case (state_q)
      S_IDLE: begin
        if (!flush && in_valid) begin
          if (div_zero || ovf) begin
            state_d      = S_DONE;
            out_valid_d  = 1'b1;
            out_result_d = spec_result;
          end else begin
            state_d   = S_CALC;
            cnt_d     = '0;
            dvd_d     = a_abs;
            dvs_d     = b_abs;
            rem_d     = '0;
            op_rem_d  = in_op[1];
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_n;
          dvd_d = dvd_n;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == CNT_LAST) begin
            state_d      = S_DONE;
            out_valid_d  = 1'b1;
            out_result_d = op_rem_q ? rem_fix : quo_fix;
          end
        end
      end
      S_DONE: begin
        if (flush || out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      rem_q        <= '0;
      op_rem_q     <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      rem_q        <= rem_d;
      op_rem_q     <= op_rem_d;
      neg_quo_q    <= neg_quo_d;
      neg_rem_q    <= neg_rem_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

endmodule

// File: tb/tb_rv32m_div_unit.sv
// tb/tb_rv32m_div_unit.sv - self-checking bench for rv32m_div_unit
module tb_rv32m_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;

  int tests = 0;
  int fails = 0;

  rv32m_div_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      OP_DIV:  if (b == 0) return 32'hFFFF_FFFF;
               else if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
               else return sa / sb;
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  if (b == 0) return a;
               else if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'd0;
               else return sa % sb;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == MIN_INT && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Starts at a falling edge in IDLE; returns at the falling edge of cycle 1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    chk("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_op    = 2'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int stall, output logic [31:0] res, output int lat);
    issue(op, a, b);
    wait_valid(lat);
    res = out_result;
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t        vecs[16];
  logic [31:0] res;
  int          lat;
  logic        seen;

  initial begin
    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
    vecs[5]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[6]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          1};
    vecs[7]  = '{OP_DIV,  MIN_INT,        32'hFFFF_FFFF,  MIN_INT,        1};
    vecs[8]  = '{OP_REM,  MIN_INT,        32'hFFFF_FFFF,  32'd0,          1};
    vecs[9]  = '{OP_DIVU, MIN_INT,        32'hFFFF_FFFF,  32'd0,          33};
    vecs[10] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vecs[11] = '{OP_REM,  MIN_INT,        32'd3,          32'hFFFF_FFFE,  33};
    vecs[12] = '{OP_DIV,  MIN_INT,        32'd2,          32'hC000_0000,  33};
    vecs[13] = '{OP_DIVU, 32'd0,          32'd5,          32'd0,          33};
    vecs[14] = '{OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1};
    vecs[15] = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};

    rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_result", out_result, 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, i % 3, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: result held, new requests ignored, not queued.
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd33);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_op = OP_DIV; in_a = 32'd9; in_b = 32'd0;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_result", out_result, 32'd14);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= out_valid; end
    chk("bp_not_queued", 32'(seen), 32'd0);

    // Flush in CALC at cycle 15.
    issue(OP_DIVU, 32'd1000, 32'd3);
    seen = 1'b0;
    repeat (14) begin seen |= out_valid; @(negedge clk); end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_early_valid", 32'(seen), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    do_op(OP_DIVU, 32'd1000, 32'd3, 0, res, lat);
    chk("after_flush_result", res, 32'd333);
    chk("after_flush_latency", 32'(lat), 32'd33);

    // Flush together with in_valid in IDLE: no accept.
    flush = 1'b1; in_valid = 1'b1; in_op = OP_DIV; in_a = 32'd5; in_b = 32'd0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("idle_flush_in_ready", 32'(in_ready), 32'd1);
    chk("idle_flush_out_valid", 32'(out_valid), 32'd0);

    // Flush in DONE drops the result.
    issue(OP_DIV, 32'd5, 32'd0);
    chk("done_flush_pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("done_flush_out_valid", 32'(out_valid), 32'd0);
    chk("done_flush_in_ready", 32'(in_ready), 32'd1);

    // Reset at cycle 20 of an op.
    do_op(OP_DIVU, 32'd77, 32'd1, 0, res, lat);
    chk("pre_reset_result", res, 32'd77);
    issue(OP_DIV, 32'hFFFF_FF9C, 32'd7);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midop_reset_out_valid", 32'(out_valid), 32'd0);
    chk("midop_reset_out_result", out_result, 32'd0);
    chk("midop_reset_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= out_valid; end
    chk("midop_reset_discarded", 32'(seen), 32'd0);

    // Randomized operations against the reference model.
    for (int n = 0; n < 1500; n++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = MIN_INT; b = 32'hFFFF_FFFF; end
        3: b = 32'hFFFF_FFFF;
        4: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(op, a, b, $urandom_range(0, 3), res, lat);
      chk($sformatf("rand%0d_op%0d_%h_%h", n, op, a, b), res, ref_result(op, a, b));
      chk($sformatf("rand%0d_latency", n), 32'(lat), 32'(ref_lat(op, a, b)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
